// File: rtl/pkt_pkg.sv
// Shared definitions for the Port_0 packet buffer: word tags, field positions,
// FSM states and a small tag decoder.
package pkt_pkg;

  localparam int WORD_W = 134;
  localparam int TAG_HI = 133;
  localparam int TAG_LO = 132;
  localparam int INV_HI = 131;
  localparam int INV_LO = 128;

  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] BODY = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  function automatic logic is_tail(input logic [1:0] tag);
    return (tag == TAIL);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, a combinational view of the head
// entry, and full/empty/used status derived from (AW+1)-bit pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] peek,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      used
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [0:(1<<AW)-1];
  logic [AW:0]      wptr_r;
  logic [AW:0]      rptr_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Pointer MSBs differ only when the FIFO has wrapped a full lap.
  assign empty   = (wptr_r == rptr_r);
  assign full    = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign used    = wptr_r - rptr_r;
  assign wr_ok_s = wr_en & ~full;
  assign rd_ok_s = rd_en & ~empty;
  assign peek    = mem_r[rptr_r[AW-1:0]];
  assign rd_data = rd_data_r;

  // Storage array write port (no reset on RAM contents).
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointer advance and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r    <= {(AW+1){1'b0}};
      rptr_r    <= {(AW+1){1'b0}};
      rd_data_r <= {WIDTH{1'b0}};
    end else begin
      if (wr_ok_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (rd_ok_s) begin
        rptr_r    <= rptr_r + PTR_ONE;
        rd_data_r <= mem_r[rptr_r[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/port0_pkt_buf.sv
// Store-and-forward packet buffer in front of Port_0: a data FIFO holds words, a
// valid FIFO holds one forward/drop flag per packet. Define PORT0_PKT_BUF_CNT_EN
// to add forwarded/dropped packet counters.
module port0_pkt_buf
  import pkt_pkg::*;
#(
  parameter int DATA_AW       = 7,
  parameter int VALID_AW      = 4,
  parameter int MAX_PKT_WORDS = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_data_wr,
  input  logic              in_data_valid,
  input  logic              in_data_valid_wr,
  output logic              in_data_alf,
  input  logic              out_rd,
  output logic [WORD_W-1:0] out_data,
  output logic              out_data_wr,
  output logic              out_data_valid,
  output logic              out_data_valid_wr,
  output logic              ovf_err
`ifdef PORT0_PKT_BUF_CNT_EN
  ,
  output logic [31:0]       fwd_pkt_cnt,
  output logic [31:0]       drop_pkt_cnt
`endif
);

  localparam logic [DATA_AW:0] DEPTH = {1'b1, {DATA_AW{1'b0}}};
  localparam logic [31:0]      MAX_W = 32'(MAX_PKT_WORDS);

  state_e              state_r, state_s;
  logic                dpop_s, vpop_s;
  logic [WORD_W-1:0]   d_rd_s, d_peek_s;
  logic                d_full_s, d_empty_s;
  logic [DATA_AW:0]    d_used_s, d_used_nxt_s, free_s;
  logic [0:0]          v_rd_s, v_peek_s;
  logic                v_full_s, v_empty_s;
  logic [VALID_AW:0]   v_used_unused_s;
  logic [INV_HI:0]     d_peek_unused_s;
  logic                tail_s, send_tail_s, d_wr_ok_s, ovf_s, alf_nxt_s;
  logic                out_data_wr_r, out_data_valid_r, out_data_valid_wr_r;
  logic                alf_r, ovf_err_r;

  sync_fifo #(.WIDTH(WORD_W), .AW(DATA_AW)) u_dfifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en(in_data_wr), .wr_data(in_data),
    .rd_en(dpop_s), .rd_data(d_rd_s), .peek(d_peek_s),
    .full(d_full_s), .empty(d_empty_s), .used(d_used_s)
  );

  sync_fifo #(.WIDTH(1), .AW(VALID_AW)) u_vfifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en(in_data_valid_wr), .wr_data(in_data_valid),
    .rd_en(vpop_s), .rd_data(v_rd_s), .peek(v_peek_s),
    .full(v_full_s), .empty(v_empty_s), .used(v_used_unused_s)
  );

  // Tail is recognised on the head entry so the FSM can leave SEND/DISCARD on the pop itself.
  assign d_peek_unused_s = d_peek_s[INV_HI:0];
  assign tail_s          = is_tail(d_peek_s[TAG_HI:TAG_LO]);
  assign send_tail_s     = (state_r == SEND) & dpop_s & tail_s;
  assign d_wr_ok_s       = in_data_wr & ~d_full_s;
  assign ovf_s           = (in_data_wr & d_full_s) | (in_data_valid_wr & v_full_s);
  assign d_used_nxt_s    = d_used_s + {{DATA_AW{1'b0}}, d_wr_ok_s} - {{DATA_AW{1'b0}}, dpop_s};
  assign free_s          = DEPTH - d_used_nxt_s;
  assign alf_nxt_s       = ({{(31-DATA_AW){1'b0}}, free_s} < MAX_W);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and FIFO pop decisions.
  always_comb begin
    state_s = state_r;
    vpop_s  = 1'b0;
    dpop_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!v_empty_s) begin
          vpop_s = 1'b1;
          if (v_peek_s[0]) state_s = SEND;
          else             state_s = DISCARD;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (out_rd && !d_empty_s) begin
          dpop_s = 1'b1;
          if (tail_s) state_s = IDLE;
          else        state_s = SEND;
        end else begin
          state_s = SEND;
        end
      end
      DISCARD: begin
        if (!d_empty_s) begin
          dpop_s = 1'b1;
          if (tail_s) state_s = IDLE;
          else        state_s = DISCARD;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output strobes, almost-full and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_wr_r       <= 1'b0;
      out_data_valid_r    <= 1'b0;
      out_data_valid_wr_r <= 1'b0;
      alf_r               <= 1'b0;
      ovf_err_r           <= 1'b0;
    end else begin
      out_data_wr_r       <= (state_r == SEND) & dpop_s;
      out_data_valid_wr_r <= send_tail_s;
      out_data_valid_r    <= send_tail_s & v_rd_s[0];
      alf_r               <= alf_nxt_s;
      ovf_err_r           <= ovf_err_r | ovf_s;
    end
  end

  assign out_data          = d_rd_s;
  assign out_data_wr       = out_data_wr_r;
  assign out_data_valid    = out_data_valid_r;
  assign out_data_valid_wr = out_data_valid_wr_r;
  assign in_data_alf       = alf_r;
  assign ovf_err           = ovf_err_r;

`ifdef PORT0_PKT_BUF_CNT_EN
  logic        drop_tail_s;
  logic [31:0] fwd_cnt_r, drop_cnt_r;

  assign drop_tail_s = (state_r == DISCARD) & dpop_s & tail_s;

  // Forwarded / dropped packet counters, wrapping naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_r  <= 32'd0;
      drop_cnt_r <= 32'd0;
    end else begin
      if (send_tail_s) fwd_cnt_r  <= fwd_cnt_r + 32'd1;
      if (drop_tail_s) drop_cnt_r <= drop_cnt_r + 32'd1;
    end
  end

  assign fwd_pkt_cnt  = fwd_cnt_r;
  assign drop_pkt_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_port0_pkt_buf.sv
// Directed bench for port0_pkt_buf: expected output words are queued as packets
// are written and compared (data and arrival cycle) as the DUT emits them.
module tb_port0_pkt_buf;
  import pkt_pkg::*;

  typedef struct {
    logic [133:0] data;
    int           cyc;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [133:0] in_data;
  logic         in_data_wr, in_data_valid, in_data_valid_wr, out_rd;
  logic         in_data_alf;
  logic [133:0] out_data;
  logic         out_data_wr, out_data_valid, out_data_valid_wr, ovf_err;
`ifdef PORT0_PKT_BUF_CNT_EN
  logic [31:0]  fwd_pkt_cnt, drop_pkt_cnt;
`endif

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  port0_pkt_buf dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_data_wr(in_data_wr),
    .in_data_valid(in_data_valid), .in_data_valid_wr(in_data_valid_wr),
    .in_data_alf(in_data_alf), .out_rd(out_rd),
    .out_data(out_data), .out_data_wr(out_data_wr),
    .out_data_valid(out_data_valid), .out_data_valid_wr(out_data_valid_wr),
    .ovf_err(ovf_err)
`ifdef PORT0_PKT_BUF_CNT_EN
    ,
    .fwd_pkt_cnt(fwd_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  function automatic logic [133:0] mk_word(input int i, input int n);
    logic [133:0] w;
    w[127:0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    w[INV_HI:INV_LO] = 4'd0;
    if (i == 0) begin
      w[TAG_HI:TAG_LO] = HEAD;
    end else if (i == n - 1) begin
      w[TAG_HI:TAG_LO] = TAIL;
      w[INV_HI:INV_LO] = 4'($urandom_range(0, 15));
    end else begin
      w[TAG_HI:TAG_LO] = BODY;
    end
    return w;
  endfunction

  // Writes an n-word packet with its flag on the tail cycle; queues the first n_exp words
  // when vld, expected at t0+3+delay+i (+stall_len from index stall_idx on).
  task automatic write_pkt(input int n, input logic vld, input int n_exp, input int delay,
                           input int stall_idx, input int stall_len, output int t0);
    logic [133:0] w;
    t0 = cyc + n - 1;
    for (int i = 0; i < n; i++) begin
      w                = mk_word(i, n);
      in_data          = w;
      in_data_wr       = 1'b1;
      in_data_valid_wr = (i == n - 1);
      in_data_valid    = vld;
      if (vld && i < n_exp)
        sb.push_back('{data: w, cyc: t0 + 3 + delay + i + ((i >= stall_idx) ? stall_len : 0),
                       last: (i == n - 1)});
      step();
    end
    in_data_wr       = 1'b0;
    in_data_valid_wr = 1'b0;
    in_data_valid    = 1'b0;
  endtask

  // Output monitor: every forwarded word must match the queue head in data and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (out_data_wr) begin
        if (sb.size() == 0) begin
          check("unexpected_wr", out_data_wr, 1'b0);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_cycle", cyc, e.cyc);
          check("valid_wr", out_data_valid_wr, e.last);
          if (out_data_valid_wr) check("valid_flag", out_data_valid, 1'b1);
        end
      end else if (out_data_valid_wr) begin
        check("stray_valid_wr", out_data_valid_wr, 1'b0);
      end
    end
  end

  initial begin
    int t0, t1, m;
    rst_n = 1'b0; in_data = '0; in_data_wr = 1'b0; in_data_valid = 1'b0;
    in_data_valid_wr = 1'b0; out_rd = 1'b1;
    repeat (3) step();
    check("rst_out_data", out_data, '0);
    check("rst_out_wr", out_data_wr, 1'b0);
    check("rst_valid", out_data_valid, 1'b0);
    check("rst_valid_wr", out_data_valid_wr, 1'b0);
    check("rst_alf", in_data_alf, 1'b0);
    check("rst_ovf", ovf_err, 1'b0);
    rst_n = 1'b1;
    step();

    // Forward one 6-word packet.
    write_pkt(6, 1'b1, 6, 0, 99, 0, t0);
    wait_until(t0 + 12);
    check("t1_drain", sb.size(), 0);
`ifdef PORT0_PKT_BUF_CNT_EN
    check("t1_fwd_cnt", fwd_pkt_cnt, 1);
`endif

    // Drop one 6-word packet.
    write_pkt(6, 1'b0, 0, 0, 99, 0, t0);
    wait_until(t0 + 8);
    check("t2_dfifo_empty", dut.u_dfifo.empty, 1'b1);
    wait_until(t0 + 10);
`ifdef PORT0_PKT_BUF_CNT_EN
    check("t2_drop_cnt", drop_pkt_cnt, 1);
`endif

    // Port stall of 4 cycles after the second output word.
    write_pkt(6, 1'b1, 6, 0, 2, 4, t0);
    wait_until(t0 + 4);
    out_rd = 1'b0;
    wait_until(t0 + 8);
    out_rd = 1'b1;
    wait_until(t0 + 16);
    check("t3_drain", sb.size(), 0);

    // Almost-full: 29 words, flag later, then discard.
    for (int i = 0; i < 29; i++) begin
      in_data    = mk_word(i, 29);
      in_data_wr = 1'b1;
      step();
      if (i == 27) check("t4_alf_28", in_data_alf, 1'b0);
    end
    in_data_wr = 1'b0;
    check("t4_alf_29", in_data_alf, 1'b1);
    in_data_valid_wr = 1'b1;
    in_data_valid    = 1'b0;
    m = cyc;
    step();
    in_data_valid_wr = 1'b0;
    wait_until(m + 2);
    check("t4_alf_hold", in_data_alf, 1'b1);
    step();
    check("t4_alf_clear", in_data_alf, 1'b0);
    wait_until(m + 34);
    check("t4_dfifo_empty", dut.u_dfifo.empty, 1'b1);

    // Back-to-back packets: one bubble between A's tail and B's head.
    write_pkt(6, 1'b1, 6, 0, 99, 0, t0);
    write_pkt(6, 1'b1, 6, 1, 99, 0, t1);
    wait_until(t1 + 15);
    check("t5_drain", sb.size(), 0);

    // Reset during SEND after the third output word.
    write_pkt(6, 1'b1, 3, 0, 99, 0, t0);
    wait_until(t0 + 6);
    rst_n = 1'b0;
    #1;
    check("t6_out_wr", out_data_wr, 1'b0);
    check("t6_valid_wr", out_data_valid_wr, 1'b0);
    check("t6_valid", out_data_valid, 1'b0);
    check("t6_out_data", out_data, '0);
    check("t6_sb_flushed", sb.size(), 0);
`ifdef PORT0_PKT_BUF_CNT_EN
    check("t6_fwd_rst", fwd_pkt_cnt, 0);
    check("t6_drop_rst", drop_pkt_cnt, 0);
`endif
    step();
    step();
    rst_n = 1'b1;
    step();
    write_pkt(6, 1'b1, 6, 0, 99, 0, t0);
    wait_until(t0 + 12);
    check("t6_drain", sb.size(), 0);
`ifdef PORT0_PKT_BUF_CNT_EN
    check("t6_fwd_cnt", fwd_pkt_cnt, 1);
`endif

    // Overflow: 129th write into a 128-word data FIFO.
    for (int i = 0; i < 128; i++) begin
      in_data    = mk_word(1, 3);
      in_data_wr = 1'b1;
      step();
    end
    in_data_wr = 1'b0;
    check("t7_ovf_full", ovf_err, 1'b0);
    in_data    = mk_word(1, 3);
    in_data_wr = 1'b1;
    step();
    in_data_wr = 1'b0;
    check("t7_ovf_set", ovf_err, 1'b1);
    repeat (3) step();
    check("t7_ovf_sticky", ovf_err, 1'b1);
    check("t7_alf_full", in_data_alf, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t7_ovf_rst", ovf_err, 1'b0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/port0_pkt_buf.md
# port0_pkt_buf

Store-and-forward packet buffer between the `mux` output and the Port_0 transmit logic. It accepts the 134-bit packet stream produced by `mux` on its `mux2port_0_*` outputs, holds each packet until its tail valid flag arrives, then either forwards it to Port_0 or silently discards it. It gives upstream an almost-full indication sized for one maximum-length packet.

## Interface
- `DATA_AW`, 7: data FIFO address width (depth 2^DATA_AW words of 134 bits).
- `VALID_AW`, 4: valid FIFO address width (depth 2^VALID_AW flags).
- `MAX_PKT_WORDS`, 100: worst-case words per packet, used for almost-full.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_data` input 134: packet word; [133:132] = 01 head, 11 body, 10 tail; [131:128] = invalid byte count on the tail word.
- `in_data_wr` input 1: `in_data` strobe.
- `in_data_valid` input 1: 1 = forward the packet, 0 = drop it.
- `in_data_valid_wr` input 1: `in_data_valid` strobe. Asserted once per packet, no earlier than the tail word's cycle.
- `in_data_alf` output 1: free data words < MAX_PKT_WORDS. Upstream must not start a new packet while this is high.
- `out_rd` input 1: Port_0 ready. Sampled every cycle.
- `out_data` output 134: forwarded word.
- `out_data_wr` output 1: `out_data` strobe.
- `out_data_valid` output 1: always 1 when `out_data_valid_wr` is high.
- `out_data_valid_wr` output 1: pulses with the tail word.
- `ovf_err` output 1: sticky. Set when a write arrives at a full FIFO.

## Operation
- **Write side**
  - Every `in_data_wr` pushes `in_data` into the data FIFO.
  - Every `in_data_valid_wr` pushes `in_data_valid` into the valid FIFO.
  - A packet is readable only once its flag is stored.
- **States**
  - IDLE: if the valid FIFO is not empty, pop one flag. Flag 1 → SEND, flag 0 → DISCARD.
  - SEND: while `out_rd`=1, pop one data word per cycle. While `out_rd`=0, no pop. After popping the word with [133:132]=10 → IDLE.
  - DISCARD: pop one word per cycle, ignoring `out_rd`, with no output strobes. After the tail pop → IDLE.
- **Overflow**
  - A write to a full data or valid FIFO is ignored and sets `ovf_err`.
  - `ovf_err` clears only on reset.
- **Empty data FIFO in SEND/DISCARD** (only possible after overflow): stall, no pop.
- **Pointers**: DATA_AW+1 / VALID_AW+1 bits wide; the MSB distinguishes full from empty. Wrap-around is natural modulo.
- **Free count**: 2^DATA_AW − (wptr − rptr), computed at DATA_AW+1 bits.

## Timing
- All outputs reset to 0 and the FSM resets to IDLE. Reset mid-packet flushes both FIFOs; partial packets are lost.
- The FIFO RAM read is registered: a pop at cycle t gives `out_data`/`out_data_wr` at t+1.
- Valid flag written at t0 (tail and `valid_wr` in the same cycle):
  - flag popped at t0+1;
  - first data pop at t0+2;
  - first `out_data_wr` at t0+3.
- `out_data_valid_wr`/`out_data_valid` are high in the same cycle as the tail's `out_data_wr`.
- After a tail pop, IDLE can pop the next flag in the following cycle. There is one bubble cycle between back-to-back packets.
- `in_data_alf` is registered: it reflects the occupancy after the previous cycle's writes and pops.

## Configuration
- With `PORT0_PKT_BUF_CNT_EN` defined, two extra outputs exist, reset to 0, wrapping at 2^32:
  - `fwd_pkt_cnt[31:0]`: +1 per SEND tail.
  - `drop_pkt_cnt[31:0]`: +1 per DISCARD tail.
- Without the macro, these ports and counters are absent; the remaining behaviour is identical.

## Structure
- Package `pkt_pkg`:
  - word-flag constants HEAD=2'b01, BODY=2'b11, TAIL=2'b10;
  - field positions [133:132] and [131:128];
  - FSM state enum IDLE/SEND/DISCARD.
- Sub-module `sync_fifo` (parameter WIDTH, AW; registered read; full/empty/used count), instantiated twice: 134-bit data FIFO and 1-bit valid FIFO.

## Test plan
- **6-word packet, valid=1, `out_rd`=1**, tail and `valid_wr` together at t0: 6 identical words out at t0+3..t0+8; `out_data_valid_wr` at t0+8 only.
- **Same packet with valid=0**: no `out_data_wr`; data FIFO empty by t0+8.
- **Stall**: `out_rd` dropped for 4 cycles after the 2nd output word → words 3–6 delayed exactly 4 cycles, none lost or duplicated.
- **Almost-full**: defaults (128 words), write 29 words with no flag → `in_data_alf`=1 the cycle after the 29th write. Push flag 0 → `in_data_alf` returns to 0 after discard.
- **Back-to-back**: packets A(valid=1) and B(valid=1) fully written → B's head appears 1 bubble cycle after A's tail.
- **Reset mid-SEND**: `rst_n` low after 3rd output word → all outputs 0 immediately. A new packet afterwards forwards cleanly. With `PORT0_PKT_BUF_CNT_EN`: counters 0 after reset, then `fwd_pkt_cnt`=1.
